// File: rtl/wb_slave_regfile_pipe_if.sv
// Wishbone B4 pipelined-mode bus bundle used by wb_slave_regfile_pipe.
// Signal names keep the slave-side _i/_o suffixes of the existing bus.
interface wb_slave_regfile_pipe_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_slave_regfile_pipe.sv
// Wishbone B4 pipelined register-file slave: byte-lane writes, fixed response latency,
// outstanding limit with stall. Define WB_REGFILE_RO_EN to make RO_MASK slots read-only ID words.
module wb_slave_regfile_pipe #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int GRANULE         = 8,
  parameter int REGISTER_NUM    = 16,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [REGISTER_NUM-1:0] RO_MASK = {REGISTER_NUM{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_slave_regfile_pipe_if.slave wb
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int OFF_W     = $clog2(SEL_WIDTH);
  localparam int IDX_W     = (REGISTER_NUM > 1) ? $clog2(REGISTER_NUM) : 1;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

`ifdef WB_REGFILE_RO_EN
  localparam logic [REGISTER_NUM-1:0] RO_EFF = RO_MASK;
`else
  // Every register is read/write in this build; RO_MASK has no effect.
  localparam logic [REGISTER_NUM-1:0] RO_EFF = RO_MASK & {REGISTER_NUM{1'b0}};
`endif

  function automatic logic [DATA_WIDTH-1:0] hw_id(input int i);
    logic [31:0] id_w;
    id_w = {16'hC0DE, 16'(i)};
    return DATA_WIDTH'(id_w);
  endfunction

  logic [ADDR_WIDTH-1:0] idx_s;
  logic [IDX_W-1:0]      reg_idx_s;
  logic                  misalign_s;
  logic                  range_err_s;
  logic                  ro_hit_s;
  logic                  dec_err_s;
  logic                  acc_s;
  logic                  wr_en_s;
  logic                  resp_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic [DATA_WIDTH-1:0] regs_r     [REGISTER_NUM];
  logic [LATENCY-1:0]    pipe_ack_r;
  logic [LATENCY-1:0]    pipe_err_r;
  logic [DATA_WIDTH-1:0] pipe_dat_r [LATENCY];
  logic [LATENCY-1:0]    ack_nxt_s;
  logic [LATENCY-1:0]    err_nxt_s;
  logic [DATA_WIDTH-1:0] dat_nxt_s  [LATENCY];
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  stall_r;
  logic                  stall_nxt_s;

  assign idx_s       = wb.adr_i >> OFF_W;
  assign reg_idx_s   = idx_s[IDX_W-1:0];
  assign misalign_s  = (wb.adr_i & ADDR_WIDTH'(SEL_WIDTH - 1)) != {ADDR_WIDTH{1'b0}};
  assign range_err_s = {1'b0, idx_s} >= (ADDR_WIDTH + 1)'(REGISTER_NUM);
  assign ro_hit_s    = RO_EFF[reg_idx_s] & ~range_err_s;

  // Request decode: acceptance, error classification and read sampling.
  always_comb begin
    acc_s     = wb.cyc_i & wb.stb_i & ~stall_r;
    dec_err_s = misalign_s | range_err_s | (wb.we_i & ro_hit_s);
    wr_en_s   = acc_s & wb.we_i & ~dec_err_s;
    if (dec_err_s || wb.we_i) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_s = regs_r[reg_idx_s];
    end
  end

  // Register bank: byte-lane writes; read-only slots keep sampling their ID word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REGISTER_NUM; i++) regs_r[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < REGISTER_NUM; i++) begin
        if (RO_EFF[i]) begin
          regs_r[i] <= hw_id(i);
        end else if (wr_en_s && (reg_idx_s == IDX_W'(i))) begin
          for (int k = 0; k < SEL_WIDTH; k++) begin
            if (wb.sel_i[k]) regs_r[i][k*GRANULE +: GRANULE] <= wb.dat_i[k*GRANULE +: GRANULE];
          end
        end
      end
    end
  end

  // Response pipeline, outstanding count and stall next state.
  // Data only advances behind a valid entry so dat_o holds between responses.
  always_comb begin
    resp_s    = pipe_ack_r[LATENCY-1] | pipe_err_r[LATENCY-1];
    ack_nxt_s = {LATENCY{1'b0}};
    err_nxt_s = {LATENCY{1'b0}};
    for (int i = 0; i < LATENCY; i++) dat_nxt_s[i] = pipe_dat_r[i];
    if (wb.cyc_i) begin
      ack_nxt_s[0] = acc_s & ~dec_err_s;
      err_nxt_s[0] = acc_s & dec_err_s;
      if (acc_s) begin
        dat_nxt_s[0] = rd_data_s;
      end else begin
        dat_nxt_s[0] = pipe_dat_r[0];
      end
      for (int i = 1; i < LATENCY; i++) begin
        ack_nxt_s[i] = pipe_ack_r[i-1];
        err_nxt_s[i] = pipe_err_r[i-1];
        if (pipe_ack_r[i-1] || pipe_err_r[i-1]) begin
          dat_nxt_s[i] = pipe_dat_r[i-1];
        end else begin
          dat_nxt_s[i] = pipe_dat_r[i];
        end
      end
      case ({acc_s, resp_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
        2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
        default: cnt_nxt_s = cnt_r;
      endcase
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
    stall_nxt_s = (cnt_nxt_s == CNT_W'(MAX_OUTSTANDING)) &
                  ~(ack_nxt_s[LATENCY-1] | err_nxt_s[LATENCY-1]);
  end

  // Pipeline, counter and stall state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_ack_r <= {LATENCY{1'b0}};
      pipe_err_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) pipe_dat_r[i] <= {DATA_WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      stall_r    <= 1'b0;
    end else begin
      pipe_ack_r <= ack_nxt_s;
      pipe_err_r <= err_nxt_s;
      for (int i = 0; i < LATENCY; i++) pipe_dat_r[i] <= dat_nxt_s[i];
      cnt_r      <= cnt_nxt_s;
      stall_r    <= stall_nxt_s;
    end
  end

  assign wb.ack_o   = pipe_ack_r[LATENCY-1];
  assign wb.err_o   = pipe_err_r[LATENCY-1];
  assign wb.dat_o   = pipe_dat_r[LATENCY-1];
  assign wb.stall_o = stall_r;
endmodule

// File: tb/tb_wb_slave_regfile_pipe.sv
// Scoreboard bench for wb_slave_regfile_pipe (LATENCY=4, MAX_OUTSTANDING=2); expected
// responses are queued at acceptance and compared in order when ack_o/err_o appear.
module tb_wb_slave_regfile_pipe;
  localparam int NREG = 16;
  localparam int LAT  = 4;
  localparam int MAXO = 2;
`ifdef WB_REGFILE_RO_EN
  localparam logic [NREG-1:0] RO_M = 16'h0001;
`else
  localparam logic [NREG-1:0] RO_M = 16'h0000;
`endif

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model_q [NREG];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_slave_regfile_pipe_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8)) bus ();

  wb_slave_regfile_pipe #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .REGISTER_NUM(NREG),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .RO_MASK(RO_M)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    if (RO_M[idx]) return {16'hC0DE, 16'(idx)};
    return model_q[idx];
  endfunction

  task automatic sb_push(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    exp_t e;
    int   idx;
    logic bad;
    idx = int'(adr >> 2);
    bad = (adr[1:0] != 2'b00) || (idx >= NREG);
    if (!bad && we && RO_M[idx]) bad = 1'b1;
    e.err     = bad;
    e.chk_dat = bad || !we;
    e.cyc     = cyc_cnt + 1;
    e.dat     = (!bad && !we) ? model_rd(idx) : 32'h0;
    if (!bad && we) begin
      for (int k = 0; k < 4; k++) if (sel[k]) model_q[idx][k*8 +: 8] = dat[k*8 +: 8];
    end
    sb_q.push_back(e);
  endtask

  // Drive one request at a negedge, hold it through stalls, return at the negedge after acceptance.
  task automatic bus_req(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    int waited = 0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.sel_i = sel;
    bus.dat_i = dat;
    while (bus.stall_o === 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.stall_o !== 1'b0) begin
      check_eq("stall_timeout", 64'd1, 64'd0);
      bus.stb_i = 1'b0;
    end else begin
      sb_push(we, adr, sel, dat);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.stb_i = 1'b0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Response monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (bus.ack_o || bus.err_o)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_resp", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("ack_err_excl", 64'(bus.ack_o & bus.err_o), 64'd0);
        check_eq("resp_err", 64'(bus.err_o), 64'(mon_e.err));
        if (mon_e.chk_dat) check_eq("resp_dat", 64'(bus.dat_o), 64'(mon_e.dat));
        check_eq("resp_lat", 64'(cyc_cnt), 64'(mon_e.cyc + LAT - 1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 16'h0;
    bus.sel_i = 4'h0;
    bus.dat_i = 32'h0;
    for (int i = 0; i < NREG; i++) model_q[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 64'(bus.ack_o), 64'd0);
    check_eq("rst_err", 64'(bus.err_o), 64'd0);
    check_eq("rst_stall", 64'(bus.stall_o), 64'd0);
    check_eq("rst_dat", 64'(bus.dat_o), 64'd0);
    rst = 1'b0;

    // Basic readback, byte lanes, no-op write, errors, last register
    bus_req(1'b0, 16'h000C, 4'hF, 32'h0);
    bus_req(1'b1, 16'h0008, 4'hF, 32'hDEADBEEF);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    bus_req(1'b1, 16'h0008, 4'b0101, 32'h11223344);
    bus_req(1'b0, 16'h0008, 4'h0, 32'h0);
    bus_req(1'b1, 16'h0008, 4'h0, 32'hFFFFFFFF);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0040, 4'hF, 32'h0);
    bus_req(1'b1, 16'h0001, 4'hF, 32'h55555555);
    bus_req(1'b1, 16'h000A, 4'hF, 32'h66666666);
    bus_req(1'b0, 16'h0000, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    bus_req(1'b1, 16'h003C, 4'hF, 32'hCAFEF00D);
    bus_req(1'b0, 16'h003C, 4'hF, 32'h0);
    bus_req(1'b1, 16'h0000, 4'hF, 32'h0BADF00D);
    bus_req(1'b0, 16'h0000, 4'hF, 32'h0);
    drain();

    // Outstanding limit: two accepts fill the window, later reads wait for responses
    for (int i = 4; i < 8; i++) bus_req(1'b1, 16'(i * 4), 4'hF, 32'hA5A50000 | 32'(i));
    drain();
    bus_req(1'b0, 16'h0010, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0014, 4'hF, 32'h0);
    check_eq("stall_after_2", 64'(bus.stall_o), 64'd1);
    bus_req(1'b0, 16'h0018, 4'hF, 32'h0);
    bus_req(1'b0, 16'h001C, 4'hF, 32'h0);
    drain();

    // Abort: drop cyc_i with two reads in flight
    bus_req(1'b0, 16'h0010, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0014, 4'hF, 32'h0);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    sb_q.delete();
    @(negedge clk);
    bus.cyc_i = 1'b1;
    check_eq("abort_stall", 64'(bus.stall_o), 64'd0);
    repeat (6) @(negedge clk);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    check_eq("abort_restall", 64'(bus.stall_o), 64'd1);
    drain();

    // Reset mid-transaction, between clock edges
    bus_req(1'b0, 16'h0004, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    check_eq("pre_rst_stall", 64'(bus.stall_o), 64'd1);
    bus.stb_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_ack", 64'(bus.ack_o), 64'd0);
    check_eq("midrst_err", 64'(bus.err_o), 64'd0);
    check_eq("midrst_stall", 64'(bus.stall_o), 64'd0);
    check_eq("midrst_dat", 64'(bus.dat_o), 64'd0);
    sb_q.delete();
    for (int i = 0; i < NREG; i++) model_q[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    bus_req(1'b0, 16'h000C, 4'hF, 32'h0);
    bus_req(1'b0, 16'h0008, 4'hF, 32'h0);
    bus_req(1'b0, 16'h003C, 4'hF, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
